ls_issue_queue: RTL and testbench
=================================

# ls_issue_queue

In-order issue queue directly upstream of the load/store execution wrapper: buffers decoded load/store instructions from dispatch, captures pending source operands from the ROB writeback bus, and presents the oldest entry to the load/store unit once both operands are known. Instructions issue strictly in program order, which keeps memory ordering trivial. It drives the LS unit's `inst`/`inst_valid`/`A`/`B`/`rob_slot` inputs and obeys its `ready` output.

## Interface
- `ROB_DEPTHLOG2`, 4, log2 of ROB entries; width of ROB slot tags.
- `DEPTHLOG2`, 2, log2 of queue entries (depth = 2**DEPTHLOG2).
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all entries (mispredict/exception).
- `in_valid`  in  1  dispatch offers an entry.
- `in_inst`  in  dec_inst_t  decoded load/store instruction.
- `in_A`, `in_B`  in  32 each  operand values (meaningful when matching `_rdy`=1).
- `in_A_rdy`, `in_B_rdy`  in  1 each  operand value already available.
- `in_A_tag`, `in_B_tag`  in  ROB_DEPTHLOG2 each  ROB slot producing the operand when not ready.
- `in_rob_slot`  in  ROB_DEPTHLOG2  ROB slot of this instruction.
- `in_ready`  out  1  queue accepts an entry this cycle.
- `wb_valid`  in  1  ROB writeback strobe.
- `wb_idx`  in  ROB_DEPTHLOG2  ROB slot being written.
- `wb_data`  in  32  written result.
- `inst`  out  dec_inst_t  head instruction.
- `inst_valid`  out  1  head entry is issuable.
- `A`, `B`  out  32 each  head operand values.
- `rob_slot`  out  ROB_DEPTHLOG2  head ROB slot.
- `ls_ready`  in  1  LS unit accepts (its `ready`).
- `occupancy`  out  DEPTHLOG2+1  number of valid entries.

## Operation
- Storage: circular buffer of 2**DEPTHLOG2 entries, each holding inst, A, B, A_rdy, B_rdy, A_tag, B_tag, rob_slot. Head/tail pointers are DEPTHLOG2 bits and wrap naturally; count is DEPTHLOG2+1 bits.
- `in_ready = (count != 2**DEPTHLOG2)`. Push = `in_valid & in_ready & ~flush`. When full, no push, even if a pop happens in the same cycle.
- `inst_valid = (count != 0) & head.A_rdy & head.B_rdy`. Pop = `inst_valid & ls_ready`. `inst`/`A`/`B`/`rob_slot` always show the head slot.
- Wakeup: every cycle with `wb_valid`, each valid entry whose operand is not ready and whose tag equals `wb_idx` stores `wb_data` and sets rdy. A and B are checked independently, so both can match at once.
- Enqueue capture: when a pushed operand is not ready and its tag equals a same-cycle `wb_idx` (with `wb_valid`), the entry is written with `wb_data` and rdy=1.
- There is no same-cycle bypass to the output. A head woken at edge N can issue in cycle N+1 at the earliest.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- `flush`: at the next edge count, head and tail become 0 and all entries are invalid. Flush overrides push, pop and wakeup. During a flush cycle `inst_valid` still reflects current state; the LS unit is flushed by the same signal.

## Timing
- Reset (async): count=0, pointers=0, all payload/rdy bits 0. So `inst_valid`=0, `in_ready`=1, `occupancy`=0, and `A`/`B`/`rob_slot`/`inst` are all zero.
- Latency: an entry pushed with both operands ready at edge N is at head (if the queue was empty) and has `inst_valid`=1 in cycle N+1.
- Throughput: one push and one pop per cycle.
- Only sequential state is the buffer, pointers and count. Output paths are combinational from state plus `ls_ready`.

## Test plan
- Reset then push one load with A_rdy=B_rdy=1, A=0x100, rob_slot=3, ls_ready=1 -> `inst_valid`=1 and `A`=0x100, `rob_slot`=3 the next cycle; popped that cycle; `occupancy` goes 1->0.
- Push 4 entries with ls_ready=0 -> `in_ready`=0 and `occupancy`=4. Offer a 5th while popping one -> it is not accepted and occupancy=3. Drain -> entries come out in push order and pointers wrap correctly over 3 refills.
- Push a store with B_rdy=0, B_tag=5; `wb_valid`,`wb_idx`=5,`wb_data`=0xDEADBEEF two cycles later -> `inst_valid` rises the cycle after the writeback with B=0xDEADBEEF.
- Push an entry with A_tag=7 not ready while `wb_idx`=7 in the same cycle, wb_data=0x42 -> entry captures A=0x42 and is issuable the next cycle.
- Head waiting on tag 2, younger entry fully ready -> younger does not issue before head (in-order); after writeback to slot 2, both issue in order on consecutive cycles.
- 3 entries queued, assert `flush` together with `in_valid` -> next cycle occupancy=0, `inst_valid`=0, pushed entry dropped. Assert reset_n low mid-operation -> outputs immediately return to reset values.

Source files
------------

// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: buffers dispatched ops, wakes operands
// from the ROB writeback bus and issues the oldest entry once both are known.
package ls_pkg;
  typedef struct packed {
    logic        is_store;
    logic [2:0]  size;
    logic [4:0]  rd;
    logic [11:0] imm;
  } dec_inst_t;
endpackage

module ls_issue_queue
  import ls_pkg::*;
#(
  parameter int ROB_DEPTHLOG2 = 4,
  parameter int DEPTHLOG2     = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  dec_inst_t                in_inst,
  input  logic [31:0]              in_A,
  input  logic [31:0]              in_B,
  input  logic                     in_A_rdy,
  input  logic                     in_B_rdy,
  input  logic [ROB_DEPTHLOG2-1:0] in_A_tag,
  input  logic [ROB_DEPTHLOG2-1:0] in_B_tag,
  input  logic [ROB_DEPTHLOG2-1:0] in_rob_slot,
  output logic                     in_ready,
  input  logic                     wb_valid,
  input  logic [ROB_DEPTHLOG2-1:0] wb_idx,
  input  logic [31:0]              wb_data,
  output dec_inst_t                inst,
  output logic                     inst_valid,
  output logic [31:0]              A,
  output logic [31:0]              B,
  output logic [ROB_DEPTHLOG2-1:0] rob_slot,
  input  logic                     ls_ready,
  output logic [DEPTHLOG2:0]       occupancy
);

  localparam int DEPTH = 1 << DEPTHLOG2;
  localparam logic [DEPTHLOG2:0] FULL = {1'b1, {DEPTHLOG2{1'b0}}};

  dec_inst_t                q_inst [DEPTH];
  logic [31:0]              q_a    [DEPTH];
  logic [31:0]              q_b    [DEPTH];
  logic [ROB_DEPTHLOG2-1:0] q_a_tag[DEPTH];
  logic [ROB_DEPTHLOG2-1:0] q_b_tag[DEPTH];
  logic [ROB_DEPTHLOG2-1:0] q_rob  [DEPTH];
  logic [DEPTH-1:0]         q_a_rdy;
  logic [DEPTH-1:0]         q_b_rdy;

  logic [DEPTHLOG2-1:0] head;
  logic [DEPTHLOG2-1:0] tail;
  logic [DEPTHLOG2:0]   count;
  logic [DEPTH-1:0]     live;
  logic                 push;
  logic                 pop;
  logic                 cap_a;
  logic                 cap_b;

  // An entry is live when its distance from head is below count.
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [DEPTHLOG2-1:0] off;
      off = DEPTHLOG2'(i) - head;
      live[i] = {1'b0, off} < count;
    end
  end

  assign in_ready   = count != FULL;
  assign push       = in_valid & in_ready & ~flush;
  assign inst_valid = (count != '0) & q_a_rdy[head] & q_b_rdy[head];
  assign pop        = inst_valid & ls_ready;
  assign cap_a      = ~in_A_rdy & wb_valid & (wb_idx == in_A_tag);
  assign cap_b      = ~in_B_rdy & wb_valid & (wb_idx == in_B_tag);

  assign inst      = q_inst[head];
  assign A         = q_a[head];
  assign B         = q_b[head];
  assign rob_slot  = q_rob[head];
  assign occupancy = count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_a_rdy <= '0;
      q_b_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i]  <= '0;
        q_a[i]     <= '0;
        q_b[i]     <= '0;
        q_a_tag[i] <= '0;
        q_b_tag[i] <= '0;
        q_rob[i]   <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (live[i] & wb_valid) begin
          if (!q_a_rdy[i] && q_a_tag[i] == wb_idx) begin
            q_a[i]     <= wb_data;
            q_a_rdy[i] <= 1'b1;
          end
          if (!q_b_rdy[i] && q_b_tag[i] == wb_idx) begin
            q_b[i]     <= wb_data;
            q_b_rdy[i] <= 1'b1;
          end
        end
      end
      // The tail slot is never live when a push is allowed.
      if (push) begin
        q_inst[tail]  <= in_inst;
        q_a[tail]     <= cap_a ? wb_data : in_A;
        q_b[tail]     <= cap_b ? wb_data : in_B;
        q_a_rdy[tail] <= in_A_rdy | cap_a;
        q_b_rdy[tail] <= in_B_rdy | cap_b;
        q_a_tag[tail] <= in_A_tag;
        q_b_tag[tail] <= in_B_tag;
        q_rob[tail]   <= in_rob_slot;
        tail          <= tail + DEPTHLOG2'(1);
      end
      if (pop) head <= head + DEPTHLOG2'(1);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_issue_queue.sv
// Bench for ls_issue_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_ls_issue_queue;
  import ls_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  dec_inst_t   in_inst;
  logic [31:0] in_A, in_B;
  logic        in_A_rdy, in_B_rdy;
  logic [3:0]  in_A_tag, in_B_tag, in_rob_slot;
  logic        in_ready;
  logic        wb_valid;
  logic [3:0]  wb_idx;
  logic [31:0] wb_data;
  dec_inst_t   inst;
  logic        inst_valid;
  logic [31:0] A, B;
  logic [3:0]  rob_slot;
  logic        ls_ready;
  logic [2:0]  occupancy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    dec_inst_t   inst;
    logic [31:0] a, b;
    bit          ar, br;
    logic [3:0]  at, bt, rob;
  } ent_t;
  ent_t mq[$];

  ls_issue_queue #(.ROB_DEPTHLOG2(4), .DEPTHLOG2(2)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst),
    .in_A(in_A), .in_B(in_B),
    .in_A_rdy(in_A_rdy), .in_B_rdy(in_B_rdy),
    .in_A_tag(in_A_tag), .in_B_tag(in_B_tag),
    .in_rob_slot(in_rob_slot), .in_ready(in_ready),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .inst(inst), .inst_valid(inst_valid),
    .A(A), .B(B), .rob_slot(rob_slot),
    .ls_ready(ls_ready), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic idle();
    flush = 0; in_valid = 0; in_inst = '0;
    in_A = 0; in_B = 0; in_A_rdy = 0; in_B_rdy = 0;
    in_A_tag = 0; in_B_tag = 0; in_rob_slot = 0;
    wb_valid = 0; wb_idx = 0; wb_data = 0;
  endtask

  task automatic offer(input logic [3:0] rob, input logic [31:0] a,
                       input logic [31:0] b, input bit ar, input bit br,
                       input logic [3:0] at, input logic [3:0] bt);
    in_valid = 1; in_rob_slot = rob;
    in_A = a; in_B = b; in_A_rdy = ar; in_B_rdy = br;
    in_A_tag = at; in_B_tag = bt;
    in_inst = {1'b0, 3'd2, 5'(rob), 12'(a)};
  endtask

  // Reference model: advance one clock edge, then move to the next negedge.
  task automatic step();
    ent_t e;
    bit iv, pp, ps;
    int n;
    if (flush) mq.delete();
    else begin
      n  = mq.size();
      iv = n > 0 && mq[0].ar && mq[0].br;
      pp = iv && ls_ready;
      ps = in_valid && n < 4;
      if (wb_valid)
        foreach (mq[i]) begin
          if (!mq[i].ar && mq[i].at == wb_idx) begin
            mq[i].a = wb_data; mq[i].ar = 1;
          end
          if (!mq[i].br && mq[i].bt == wb_idx) begin
            mq[i].b = wb_data; mq[i].br = 1;
          end
        end
      if (pp) void'(mq.pop_front());
      if (ps) begin
        e.inst = in_inst; e.rob = in_rob_slot;
        e.at = in_A_tag; e.bt = in_B_tag;
        e.ar = in_A_rdy || (wb_valid && wb_idx == in_A_tag);
        e.br = in_B_rdy || (wb_valid && wb_idx == in_B_tag);
        e.a = in_A_rdy ? in_A : wb_data;
        e.b = in_B_rdy ? in_B : wb_data;
        mq.push_back(e);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle(); ls_ready = 0; reset_n = 0; mq.delete();
    @(negedge clock); @(negedge clock); #1;
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_iv got %b exp 0", inst_valid); end
    tests++; if ({A, B, rob_slot, inst} !== '0) begin fails++; $display("FAIL reset_payload got %h/%h/%h/%h exp 0", A, B, rob_slot, inst); end
    @(negedge clock); reset_n = 1;
  endtask

  task automatic test_single();
    idle(); ls_ready = 1;
    offer(4'd3, 32'h100, 32'h8, 1, 1, 0, 0);
    step(); idle(); #1;
    tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL single_iv got %b exp 1", inst_valid); end
    tests++; if (A !== 32'h100) begin fails++; $display("FAIL single_A got %h exp 100", A); end
    tests++; if (rob_slot !== 4'd3) begin fails++; $display("FAIL single_rob got %0d exp 3", rob_slot); end
    tests++; if (occupancy !== 3'd1) begin fails++; $display("FAIL single_occ1 got %0d exp 1", occupancy); end
    step(); #1;
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL single_occ0 got %0d exp 0", occupancy); end
  endtask

  task automatic test_full_wrap();
    idle(); ls_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      offer(4'(k), 32'(k), 0, 1, 1, 0, 0); step();
    end
    idle(); #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL full_occ got %0d exp 4", occupancy); end
    offer(4'd9, 0, 0, 1, 1, 0, 0); ls_ready = 1;
    step(); idle(); #1;
    tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL full_pushpop_occ got %0d exp 3", occupancy); end
    for (int k = 2; k <= 4; k++) begin
      #1;
      tests++; if (rob_slot !== 4'(k) || inst_valid !== 1'b1) begin fails++; $display("FAIL drain_order got %0d/%b exp %0d/1", rob_slot, inst_valid, k); end
      step();
    end
    for (int r = 0; r < 3; r++) begin
      ls_ready = 0;
      for (int k = 0; k < 3; k++) begin
        offer(4'(r * 4 + k), 0, 0, 1, 1, 0, 0); step();
      end
      idle(); ls_ready = 1;
      for (int k = 0; k < 3; k++) begin
        #1;
        tests++; if (rob_slot !== 4'(r * 4 + k)) begin fails++; $display("FAIL wrap_order got %0d exp %0d", rob_slot, r * 4 + k); end
        step();
      end
    end
    #1;
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL wrap_empty got %0d exp 0", occupancy); end
  endtask

  task automatic test_wakeup();
    idle(); ls_ready = 0;
    offer(4'd8, 32'h11, 0, 1, 0, 0, 4'd5);
    in_inst.is_store = 1;
    step(); idle(); #1;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL wake_wait got %b exp 0", inst_valid); end
    step();
    wb_valid = 1; wb_idx = 4'd5; wb_data = 32'hDEADBEEF; #1;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL wake_nobypass got %b exp 0", inst_valid); end
    step(); idle(); #1;
    tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL wake_iv got %b exp 1", inst_valid); end
    tests++; if (B !== 32'hDEADBEEF) begin fails++; $display("FAIL wake_B got %h exp deadbeef", B); end
    ls_ready = 1; step();
  endtask

  task automatic test_capture();
    idle(); ls_ready = 0;
    offer(4'd4, 0, 32'h9, 0, 1, 4'd7, 0);
    wb_valid = 1; wb_idx = 4'd7; wb_data = 32'h42;
    step(); idle(); #1;
    tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL cap_iv got %b exp 1", inst_valid); end
    tests++; if (A !== 32'h42) begin fails++; $display("FAIL cap_A got %h exp 42", A); end
    ls_ready = 1; step();
  endtask

  task automatic test_in_order();
    idle(); ls_ready = 1;
    offer(4'd1, 0, 32'h5, 0, 1, 4'd2, 0); step();
    offer(4'd6, 32'h66, 32'h67, 1, 1, 0, 0); step();
    idle(); #1;
    tests++; if (inst_valid !== 1'b0 || rob_slot !== 4'd1) begin fails++; $display("FAIL order_block got %b/%0d exp 0/1", inst_valid, rob_slot); end
    step();
    wb_valid = 1; wb_idx = 4'd2; wb_data = 32'h77;
    step(); idle(); #1;
    tests++; if (inst_valid !== 1'b1 || rob_slot !== 4'd1 || A !== 32'h77) begin fails++; $display("FAIL order_head got %b/%0d/%h exp 1/1/77", inst_valid, rob_slot, A); end
    step(); #1;
    tests++; if (inst_valid !== 1'b1 || rob_slot !== 4'd6) begin fails++; $display("FAIL order_young got %b/%0d exp 1/6", inst_valid, rob_slot); end
    step(); #1;
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL order_empty got %0d exp 0", occupancy); end
  endtask

  task automatic test_flush();
    idle(); ls_ready = 0;
    for (int k = 0; k < 3; k++) begin
      offer(4'(k), 0, 0, 1, 1, 0, 0); step();
    end
    offer(4'd12, 0, 0, 1, 1, 0, 0); flush = 1;
    step(); idle(); #1;
    tests++; if (occupancy !== 3'd0 || inst_valid !== 1'b0) begin fails++; $display("FAIL flush got %0d/%b exp 0/0", occupancy, inst_valid); end
    step(); #1;
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL flush_drop got %0d exp 0", occupancy); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    bit exp_iv;
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      in_valid = r[0]; in_A_rdy = r[1]; in_B_rdy = r[2];
      wb_valid = r[3]; ls_ready = r[5:4] != 0;
      flush = $urandom_range(0, 39) == 0;
      in_A_tag = 4'($urandom_range(0, 3));
      in_B_tag = 4'($urandom_range(0, 3));
      wb_idx = 4'($urandom_range(0, 3));
      in_rob_slot = 4'($urandom);
      in_A = $urandom; in_B = $urandom; wb_data = $urandom;
      r = $urandom; in_inst = r[$bits(dec_inst_t)-1:0];
      #1;
      exp_iv = mq.size() > 0 && mq[0].ar && mq[0].br;
      tests++; if (occupancy !== 3'(mq.size())) begin fails++; $display("FAIL rnd_occ cyc %0d got %0d exp %0d", c, occupancy, mq.size()); end
      tests++; if (in_ready !== (mq.size() < 4)) begin fails++; $display("FAIL rnd_in_ready cyc %0d got %b", c, in_ready); end
      tests++; if (inst_valid !== exp_iv) begin fails++; $display("FAIL rnd_iv cyc %0d got %b exp %b", c, inst_valid, exp_iv); end
      if (mq.size() > 0) begin
        tests++; if (rob_slot !== mq[0].rob || inst !== mq[0].inst) begin fails++; $display("FAIL rnd_head cyc %0d got %0d exp %0d", c, rob_slot, mq[0].rob); end
      end
      if (exp_iv) begin
        tests++; if (A !== mq[0].a || B !== mq[0].b) begin fails++; $display("FAIL rnd_ops cyc %0d got %h/%h exp %h/%h", c, A, B, mq[0].a, mq[0].b); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); flush = 1; step();
    idle(); ls_ready = 0;
    offer(4'd10, 32'h55, 32'h66, 1, 1, 0, 0); step();
    offer(4'd11, 32'h1, 32'h2, 1, 1, 0, 0); step();
    idle(); #1;
    tests++; if (occupancy !== 3'd2 || inst_valid !== 1'b1) begin fails++; $display("FAIL mid_pre got %0d/%b exp 2/1", occupancy, inst_valid); end
    reset_n = 0; mq.delete(); #1;
    tests++; if (occupancy !== 3'd0 || inst_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ctl got %0d/%b/%b", occupancy, inst_valid, in_ready); end
    tests++; if ({A, B, rob_slot, inst} !== '0) begin fails++; $display("FAIL mid_reset_payload got %h/%h/%h", A, B, rob_slot); end
    @(negedge clock); reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_wrap();
    test_wakeup();
    test_capture();
    test_in_order();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
